// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared command codes and transmitter FSM state type for the authorization link
//
// Purpose: definitions shared by the remote-side transmitter and the Segway-side
//          authorization receiver.
// Contents:
//   CMD_GO          8'h67 ('g'), requests power up
//   CMD_STOP        8'h73 ('s'), requests power down
//   auth_tx_state_t transmitter FSM states
package auth_pkg;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } auth_tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART serializer with baud and bit counters
//
// Purpose: sends one 8N1 frame per trmt pulse. The frame is start(0), 8 data
//          bits LSB first, then stop(1). Each bit lasts BAUD_DIV clocks.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset; TX goes high at once
//   trmt     in   start a frame with tx_data; ignored while a frame is in flight
//   tx_data  in   byte to send
//   TX       out  serial line, idle high
//   tx_done  out  1-cycle pulse on the clock after the stop bit ends
module uart_tx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [9:0]        tx_shift;
  logic              shifting;
  logic              baud_end;

  assign baud_end = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

  // The line is driven straight from bit 0 of the shift register. The register
  // resets to all ones and shifts ones in, so the line idles high.
  assign TX = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      shifting <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt && !shifting) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        shifting <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (shifting) begin
        if (baud_end) begin
          baud_cnt <= '0;
          tx_shift <= {1'b1, tx_shift[9:1]};
          if (bit_cnt == 4'd9) begin
            shifting <= 1'b0;
            bit_cnt  <= '0;
            tx_done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/auth_cmd_tx.sv
// rtl/auth_cmd_tx.sv - remote-side authorization command transmitter (GO/STOP over UART)
//
// Purpose: turns go/stop request pulses into UART command bytes. It holds one
//          pending request, where the last request wins. It puts an idle gap
//          between frames. It tracks the last command that was fully sent.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset; aborts any frame in flight
//   go_req   in   1-cycle pulse, request to send GO
//   stop_req in   1-cycle pulse, request to send STOP (wins over go_req)
//   TX       out  UART serial out, idle high
//   busy     out  high from frame load until the inter-frame gap ends
//   tx_done  out  1-cycle pulse after each frame's stop bit
//   armed    out  1 after a GO frame completes, 0 after a STOP frame completes
module auth_cmd_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV = 5208,
  parameter int GAP_BITS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go_req,
  input  logic stop_req,
  output logic TX,
  output logic busy,
  output logic tx_done,
  output logic armed
);

  localparam int GAP_LEN = GAP_BITS * BAUD_DIV;
  localparam int GAP_W   = (GAP_LEN > 2) ? $clog2(GAP_LEN) : 1;

  auth_tx_state_t state, next_state;

  logic             pend_valid;
  logic [7:0]       pend_cmd;
  logic [7:0]       sent_cmd;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_end;
  logic             trmt;
  logic             u_done;

  // The tx_done cycle in SEND already holds the line idle. It counts as the
  // first gap cycle. So the GAP state lasts GAP_LEN-1 cycles, and frame starts
  // are (10+GAP_BITS)*BAUD_DIV + 2 clocks apart, with the extra 2 clocks
  // coming from IDLE and LOAD.
  assign gap_end = (gap_cnt == GAP_W'(GAP_LEN - 2));
  assign tx_done = u_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    trmt       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pend_valid) next_state = LOAD;
      end
      LOAD: begin
        trmt       = 1'b1;
        next_state = SEND;
      end
      SEND: if (u_done) next_state = GAP;
      GAP:  if (gap_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pending slot. A new request beats the clear in LOAD, so a request that
  // lands on the consume cycle becomes the next pending command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_cmd   <= CMD_STOP;
    end else if (go_req || stop_req) begin
      pend_valid <= 1'b1;
      pend_cmd   <= stop_req ? CMD_STOP : CMD_GO;
    end else if (state == LOAD) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_cmd <= CMD_STOP;
      gap_cnt  <= '0;
      armed    <= 1'b0;
    end else begin
      if (state == LOAD) sent_cmd <= pend_cmd;
      if (state == GAP && !gap_end) gap_cnt <= gap_cnt + 1'b1;
      else                          gap_cnt <= '0;
      if (state == SEND && u_done) armed <= (sent_cmd == CMD_GO);
    end
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(pend_cmd),
    .TX     (TX),
    .tx_done(u_done)
  );

endmodule
